// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its selector.
package uart_arb_pkg;

  // IDLE: looking for a grant.  WAIT_BUSY: a byte was issued, waiting for the
  // transmitter to take it (txReady low) or for the guard interval to expire.
  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_BUSY = 1'b1
  } arb_state_e;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int owner_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority selector: the first set bit of reqValid, searching from
// rrPtr upward and wrapping at N. Purely combinational.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int  N = 4,
  localparam int W = owner_width(N)
) (
  input  logic [N-1:0] reqValid,
  input  logic [W-1:0] rrPtr,
  output logic         found,
  output logic [W-1:0] index
);

  int           pos;
  logic [W-1:0] pos_idx;

  // Walk the N positions starting at rrPtr; wrap with an explicit compare so
  // N need not be a power of two.
  always_comb begin
    found   = 1'b0;
    index   = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(rrPtr) + k;
      if (pos >= N) pos = pos - N;
      pos_idx = W'(pos);
      if (!found && reqValid[pos_idx]) begin
        found = 1'b1;
        index = pos_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N byte streams.
// A granted requester keeps the transmitter until it sends a byte marked last,
// so packets never interleave; an owner that goes silent mid-packet loses the
// lock after LOCK_TIMEOUT idle clocks.
//
// Handshakes: a requester holds reqValid/reqData/reqLast stable until it sees
// its one-cycle reqAck, then advances or drops them on that edge. The arbiter
// only issues when txReady=1 and emits a one-cycle transmitReq; it then waits
// for txReady to fall (or BUSY_GUARD clocks) before it samples requests again.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int  N            = 4,
  parameter int  LOCK_TIMEOUT = 65535,
  parameter int  BUSY_GUARD   = 3,
  localparam int W            = owner_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [N-1:0]   reqValid,
  input  logic [8*N-1:0] reqData,
  input  logic [N-1:0]   reqLast,
  output logic [N-1:0]   reqAck,
  input  logic           txReady,
  output logic [7:0]     txData,
  output logic           transmitReq,
  output logic [W-1:0]   grantOwner,
  output logic           locked,
  output logic           timeoutErr,
  output logic           fsm_state
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam int GW = (BUSY_GUARD > 1) ? $clog2(BUSY_GUARD + 1) : 1;

  arb_state_e    state;
  logic [W-1:0]  rr_ptr;
  logic [CW-1:0] idle_cnt;
  logic [GW-1:0] busy_cnt;

  logic          pick_found;
  logic [W-1:0]  pick_idx;
  logic          cand_ok;
  logic [W-1:0]  cand_idx;
  logic [7:0]    cand_data;
  logic          cand_last;
  logic          grant;
  logic          owner_idle;

  function automatic logic [W-1:0] wrap_next(input logic [W-1:0] i);
    return (i == W'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  uart_rr_pick #(.N(N)) u_pick (
    .reqValid (reqValid),
    .rrPtr    (rr_ptr),
    .found    (pick_found),
    .index    (pick_idx)
  );

  // Candidate: while locked only the owner may send, otherwise the rotating pick.
  always_comb begin
    cand_ok   = 1'b0;
    cand_idx  = '0;
    cand_data = '0;
    cand_last = 1'b0;
    if (locked) begin
      cand_ok  = reqValid[grantOwner];
      cand_idx = grantOwner;
    end else begin
      cand_ok  = pick_found;
      cand_idx = pick_idx;
    end
    for (int i = 0; i < N; i++) begin
      if (cand_idx == W'(i)) begin
        cand_data = reqData[8*i +: 8];
        cand_last = reqLast[i];
      end
    end
  end

  assign grant      = (state == IDLE) && enable && txReady && cand_ok;
  assign owner_idle = locked && !reqValid[grantOwner];
  assign fsm_state  = (state == WAIT_BUSY);

  // Arbitration FSM with registered outputs, lock bookkeeping and timeouts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      idle_cnt    <= '0;
      busy_cnt    <= '0;
      reqAck      <= '0;
      txData      <= '0;
      transmitReq <= 1'b0;
      grantOwner  <= '0;
      locked      <= 1'b0;
      timeoutErr  <= 1'b0;
    end else begin
      transmitReq <= 1'b0;
      reqAck      <= '0;
      timeoutErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            txData           <= cand_data;
            transmitReq      <= 1'b1;
            reqAck[cand_idx] <= 1'b1;
            grantOwner       <= cand_idx;
            idle_cnt         <= '0;
            busy_cnt         <= '0;
            locked           <= !cand_last;
            if (cand_last) rr_ptr <= wrap_next(cand_idx);
            state            <= WAIT_BUSY;
          end else if (owner_idle) begin
            // Silent owner mid-packet: count, and force the lock off at the limit.
            if (idle_cnt == CW'(LOCK_TIMEOUT - 1)) begin
              locked     <= 1'b0;
              timeoutErr <= 1'b1;
              rr_ptr     <= wrap_next(grantOwner);
              idle_cnt   <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        WAIT_BUSY: begin
          if (!txReady || busy_cnt == GW'(BUSY_GUARD - 1)) begin
            state <= IDLE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queued requesters, a transmitter
// model and a transaction-level arbitration model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int LT = 20;
  localparam int BG = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [N-1:0]  reqValid;
  logic [8*N-1:0] reqData;
  logic [N-1:0]  reqLast;
  logic [N-1:0]  reqAck;
  logic          txReady;
  logic [7:0]    txData;
  logic          transmitReq;
  logic [1:0]    grantOwner;
  logic          locked;
  logic          timeoutErr;
  logic          fsm_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .LOCK_TIMEOUT(LT), .BUSY_GUARD(BG)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .reqValid    (reqValid),
    .reqData     (reqData),
    .reqLast     (reqLast),
    .reqAck      (reqAck),
    .txReady     (txReady),
    .txData      (txData),
    .transmitReq (transmitReq),
    .grantOwner  (grantOwner),
    .locked      (locked),
    .timeoutErr  (timeoutErr),
    .fsm_state   (fsm_state)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;

  logic [8:0] req_mem [N][64];   // {last, data} per requester
  int         head [N];
  int         tail [N];
  logic [9:0] exp_q [$];         // expected issue order {owner, data}

  int model_ptr;
  int model_owner;
  bit model_locked;

  int busy_left;
  int busy_len;
  bit hold_busy;
  bit stuck;
  bit rand_en;
  bit issued;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_first(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += tail[i] - head[i];
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic update_reqs();
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i]) begin
        reqValid[i]       = 1'b1;
        reqData[8*i +: 8] = req_mem[i][head[i]][7:0];
        reqLast[i]        = req_mem[i][head[i]][8];
      end else begin
        reqValid[i]       = 1'b0;
        reqData[8*i +: 8] = 8'h00;
        reqLast[i]        = 1'b0;
      end
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic last);
    if (tail[r] < 64) begin
      req_mem[r][tail[r]] = {last, d};
      tail[r]++;
    end
  endtask

  task automatic push_packet(input int r, input int len);
    for (int k = 0; k < len; k++) push_byte(r, 8'($urandom_range(0, 255)), (k == len - 1));
  endtask

  task automatic reset_hold();
    rst = 1'b0;
    enable = 1'b1; txReady = 1'b1;
    busy_left = 0; busy_len = 3; hold_busy = 0; stuck = 0; rand_en = 0;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    exp_q.delete();
    model_ptr = 0; model_owner = 0; model_locked = 0;
    update_reqs();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_hold();
    rst = 1'b1;
  endtask

  // One clock: observe at the falling edge, score any issue, then update the
  // transmitter and requester models for the next rising edge.
  task automatic tick();
    int         eo;
    logic [8:0] hb;
    logic [9:0] e;
    @(negedge clk);
    issued = 0;
    if (transmitReq === 1'b1) begin
      issued = 1;
      check("issue_enable", 32'(enable), 1);
      check("issue_ready", 32'(txReady), 1);
      eo = model_locked ? model_owner : rr_first(reqValid, model_ptr);
      if (eo < 0 || head[eo] >= tail[eo]) begin
        check("issue_unexpected_owner", 32'(grantOwner), 32'hFFFF_FFFF);
      end else begin
        hb = req_mem[eo][head[eo]];
        check("owner", 32'(grantOwner), eo);
        check("tx_data", 32'(txData), 32'(hb[7:0]));
        check("ack", 32'(reqAck), 1 << eo);
        check("locked", 32'(locked), 32'(!hb[8]));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("order", 32'({grantOwner, txData}), 32'(e));
        end
        model_owner  = eo;
        model_locked = !hb[8];
        if (hb[8]) model_ptr = (eo + 1) % N;
        head[eo]++;
      end
    end else begin
      check("ack_idle", 32'(reqAck), 0);
    end
    if (timeoutErr === 1'b1) begin
      model_locked = 0;
      model_ptr    = (model_owner + 1) % N;
    end
    if (issued && !stuck) begin
      txReady   = 1'b0;
      busy_left = busy_len;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) txReady = 1'b1;
    end
    if (hold_busy) txReady = 1'b0;
    if (rand_en) enable = ($urandom_range(0, 3) != 0);
    update_reqs();
  endtask

  task automatic wait_issue(input int budget, input string tag);
    issued = 0;
    for (int n = 0; n < budget && !issued; n++) tick();
    check(tag, 32'(issued), 1);
  endtask

  task automatic drain(input int budget, input string tag);
    for (int n = 0; n < budget && pending() > 0; n++) tick();
    repeat (5) tick();
    check({tag, "_left"}, pending(), 0);
    check({tag, "_exp_q"}, exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int n_iss;
    int to_at;
    rst = 1'b1; enable = 1'b1; txReady = 1'b1;
    reqValid = '0; reqData = '0; reqLast = '0;
    #2;

    // Reset values while rst is held low
    reset_hold();
    check("rst_ack", 32'(reqAck), 0);
    check("rst_txdata", 32'(txData), 0);
    check("rst_txreq", 32'(transmitReq), 0);
    check("rst_owner", 32'(grantOwner), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_timeout", 32'(timeoutErr), 0);
    check("rst_state", 32'(fsm_state), 0);
    rst = 1'b1;

    // Single requester, then pointer must have moved past requester 1
    push_byte(1, 8'h41, 1'b1);
    exp_q.push_back({2'd1, 8'h41});
    update_reqs();
    wait_issue(10, "single_wait");
    push_byte(0, 8'h50, 1'b1);
    push_byte(3, 8'h53, 1'b1);
    exp_q.push_back({2'd3, 8'h53});
    exp_q.push_back({2'd0, 8'h50});
    update_reqs();
    drain(200, "rr_after_single");

    // Round-robin fairness with a slow transmitter
    do_reset();
    busy_len = 10;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        push_byte(i, 8'(8'h80 + 16 * k + i), 1'b1);
        exp_q.push_back({2'(i), 8'(8'h80 + 16 * k + i)});
      end
    update_reqs();
    drain(1000, "fair");

    // Packet lock: requester 2's packet stays contiguous, then 3 before 0
    do_reset();
    push_byte(1, 8'h21, 1'b1);
    exp_q.push_back({2'd1, 8'h21});
    update_reqs();
    drain(200, "lock_pre");
    push_byte(2, 8'h10, 1'b0); push_byte(2, 8'h11, 1'b0); push_byte(2, 8'h12, 1'b1);
    push_byte(0, 8'hA0, 1'b1); push_byte(0, 8'hA1, 1'b1);
    push_byte(3, 8'h30, 1'b1);
    exp_q.push_back({2'd2, 8'h10}); exp_q.push_back({2'd2, 8'h11});
    exp_q.push_back({2'd2, 8'h12}); exp_q.push_back({2'd3, 8'h30});
    exp_q.push_back({2'd0, 8'hA0}); exp_q.push_back({2'd0, 8'hA1});
    update_reqs();
    drain(500, "lock");

    // Lock timeout: owner 1 goes silent mid-packet
    do_reset();
    push_byte(1, 8'h55, 1'b0);
    exp_q.push_back({2'd1, 8'h55});
    update_reqs();
    wait_issue(20, "to_issue");
    push_byte(3, 8'h33, 1'b1);
    exp_q.push_back({2'd3, 8'h33});
    update_reqs();
    to_at = -1;
    for (int t = 1; t <= 60 && to_at < 0; t++) begin
      tick();
      if (timeoutErr === 1'b1) begin
        to_at = t;
        check("to_locked", 32'(locked), 0);
      end
    end
    check("to_delay", to_at, LT + 1);
    tick();
    check("to_pulse_width", 32'(timeoutErr), 0);
    drain(100, "to_next");

    // Flow control: no issue while txReady is low; withdrawn request never acked
    do_reset();
    busy_len = 20; hold_busy = 1; txReady = 1'b0;
    push_byte(0, 8'hC0, 1'b1);
    push_byte(2, 8'hC2, 1'b1);
    update_reqs();
    n_iss = 0;
    for (int t = 0; t < 50; t++) begin
      tick();
      n_iss += int'(issued);
      if (t == 25) begin head[2] = tail[2]; update_reqs(); end
    end
    check("flow_blocked", n_iss, 0);
    hold_busy = 0; txReady = 1'b1;
    exp_q.push_back({2'd0, 8'hC0});
    n_iss = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      n_iss += int'(issued);
    end
    check("flow_one_issue", n_iss, 1);
    check("flow_pending", pending(), 0);

    // Busy guard: transmitter never drops txReady
    do_reset();
    stuck = 1;
    for (int k = 0; k < 3; k++) push_byte(0, 8'(8'hE0 + k), 1'b1);
    update_reqs();
    wait_issue(10, "guard_wait");
    check("guard_wb0", 32'(fsm_state), 1);
    tick(); check("guard_wb1", 32'(fsm_state), 1);
    tick(); check("guard_wb2", 32'(fsm_state), 1);
    tick(); check("guard_idle", 32'(fsm_state), 0);
    check("guard_gap_req", 32'(transmitReq), 0);
    tick(); check("guard_reissue", 32'(transmitReq), 1);
    drain(100, "guard");

    // Asynchronous reset in the issue cycle
    do_reset();
    push_byte(2, 8'hE2, 1'b0);
    update_reqs();
    wait_issue(10, "arst_wait");
    rst = 1'b0;
    #1;
    check("arst_txreq", 32'(transmitReq), 0);
    check("arst_ack", 32'(reqAck), 0);
    check("arst_locked", 32'(locked), 0);
    check("arst_state", 32'(fsm_state), 0);
    do_reset();
    push_byte(3, 8'hF3, 1'b1);
    push_byte(0, 8'hF0, 1'b1);
    exp_q.push_back({2'd0, 8'hF0});
    exp_q.push_back({2'd3, 8'hF3});
    update_reqs();
    drain(200, "arst_resume");

    // Randomized packets, transmitter latency and enable gating
    do_reset();
    rand_en = 1;
    for (int round = 0; round < 8; round++) begin
      for (int r = 0; r < N; r++)
        if ($urandom_range(0, 1) == 1) push_packet(r, $urandom_range(1, 3));
      busy_len = $urandom_range(1, 12);
      update_reqs();
      drain(2000, "rand");
    end
    rand_en = 0;
    enable = 1'b1;

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UartTransmitter between N byte-stream requesters, for example a command-echo path and a status reporter.
- Round-robin arbitration with packet locking. Once a requester is granted, it keeps the transmitter until it sends a byte marked last, so packets never interleave on the wire.
- Sits between the requesters and the transmitter's data/transmitReq/ready interface, in the same clock domain as the UART.

Parameters:
- N, 4, number of requesters (1..8).
- LOCK_TIMEOUT, 65535, clocks an idle locked owner may hold the transmitter before the lock is forcibly released.
- BUSY_GUARD, 3, maximum clocks to wait for txReady to fall after issuing a byte.

Ports:
- clk  in  1  system clock; all state updates on posedge clk.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  when 0, no new grants are made; an in-flight byte completes.
- reqValid  in  N  requester i has a byte pending.
- reqData  in  8*N  byte of requester i at [8i+7:8i].
- reqLast  in  N  pending byte of requester i ends its packet.
- reqAck  out  N  one-cycle pulse: requester i's byte was issued.
- txReady  in  1  transmitter ready.
- txData  out  8  byte to transmitter.
- transmitReq  out  1  one-cycle issue strobe to transmitter.
- grantOwner  out  max(1,clog2 N)  index of the current or most recent owner.
- locked  out  1  a packet is in progress; only grantOwner may send.
- timeoutErr  out  1  one-cycle pulse when a lock is forcibly released.

Behaviour:
- Reset (rst=0, asynchronous):
  - reqAck=0, txData=0, transmitReq=0, grantOwner=0, locked=0, timeoutErr=0.
  - rrPtr=0, idle counter=0, state=IDLE.
  - transmitReq drops immediately, even mid-issue; a byte already latched by the transmitter is not the arbiter's concern.
- States: IDLE and WAIT_BUSY.
- IDLE, grant condition: enable=1 and txReady=1 and a candidate exists.
  - Not locked: the candidate is the first i with reqValid[i]=1, searching rrPtr, rrPtr+1, ... and wrapping modulo N.
  - Locked: the only candidate is grantOwner; reqValid of every other requester is ignored.
- IDLE, on a grant to requester i, the following are registered so they are visible the cycle after the sampling edge (1-cycle latency):
  - txData<=reqData[i], transmitReq<=1, reqAck[i]<=1, grantOwner<=i, idle counter<=0.
  - If reqLast[i]=1: locked<=0 and rrPtr<=(i+1) mod N.
  - Else: locked<=1 and rrPtr is unchanged.
  - Next state is WAIT_BUSY.
- transmitReq and reqAck are single-cycle pulses: they clear on the following edge.
  - On the edge where a requester sees reqAck, it must advance or drop reqValid/reqData. The arbiter does not resample that requester while in WAIT_BUSY.
- WAIT_BUSY: return to IDLE on the first cycle txReady=0, or after BUSY_GUARD cycles.
  - Because IDLE requires txReady=1 before any grant, this guarantees one byte per transmitter acceptance.
- Lock timeout:
  - In IDLE with locked=1 and reqValid[grantOwner]=0, the idle counter increments each cycle.
  - Any grant clears the counter.
  - When the counter reaches LOCK_TIMEOUT: locked<=0, timeoutErr pulses for 1 cycle, rrPtr<=(grantOwner+1) mod N, counter<=0.
- enable=0:
  - Blocks grants only.
  - The lock is retained, and the timeout still counts (there is no reqValid from the owner), so a stuck packet still releases.
- Requester withdraws reqValid before a grant: this is legal and no ack is issued.
- N=1: rrPtr is always 0; locking still applies.
- rrPtr and grantOwner wrap modulo N with explicit compare, since N need not be a power of two.

Decomposition:
- Package uart_arb_pkg: state enum {IDLE, WAIT_BUSY} and the helper function for owner index width.
- Sub-module uart_rr_pick: purely combinational rotate-priority selector.
  - Inputs: reqValid, rrPtr.
  - Outputs: found, index.
  - Reusable for a future receive-side dispatcher.

Test Plan:
- Single requester: N=4, reqValid=4'b0010, reqData[15:8]=8'h41, reqLast[1]=1, txReady=1 → next cycle transmitReq=1, txData=8'h41, reqAck=4'b0010, grantOwner=1, locked=0; rrPtr becomes 2.
- Round-robin fairness: all four requesters valid with reqLast=1 continuously, transmitter model dropping ready for 10 clocks per byte → grant order 0,1,2,3,0,1.
- Packet lock: requester 2 sends 8'h10,8'h11,8'h12 (last on the third byte) while requester 0 is valid throughout → bytes 10,11,12 go out contiguously, locked=1 until the third ack, then requester 3's turn comes before requester 0 (requester 0 goes next if 3 is idle).
- Lock timeout: LOCK_TIMEOUT=20, requester 1 sends a non-last byte then drops reqValid → timeoutErr pulses exactly 20 IDLE cycles later, locked=0, and the pending requester 3 is granted next.
- Flow control: txReady held 0 with requests pending → no transmitReq or reqAck for 50 cycles; txReady rises → exactly one issue. BUSY_GUARD expiry with txReady stuck at 1 → return to IDLE after 3 cycles.
- Async reset mid-issue: assert rst=0 in the cycle transmitReq=1 → transmitReq, reqAck and locked drop immediately; after release, grants resume from requester 0.
